// File: rtl/node_feeder.sv
// node_feeder: streams weight words, digit words and per-group bias bytes from
// three synchronous-read memories into the a/b/bias/ready inputs of a nodeFunc
// MAC node. One start pulse streams N_WORDS words; a new bias is loaded every
// WORDS_PER_NODE words.
// Optional feature: define NODE_FEEDER_PAUSE_EN to honour the downstream
// 'pause' hold, which parks the in-flight read in a one-entry skid register.
module node_feeder #(
    parameter int WORD_W         = 128,
    parameter int BIAS_W         = 8,
    parameter int N_WORDS        = 40,
    parameter int WORDS_PER_NODE = 4,
    parameter int ADDR_W         = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [0:WORD_W-1] w_data,
    output logic [ADDR_W-1:0] d_addr,
    input  logic [0:WORD_W-1] d_data,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [0:BIAS_W-1] b_data,
    output logic [0:WORD_W-1] a,
    output logic [0:WORD_W-1] b,
    output logic [0:BIAS_W-1] bias,
    output logic              ready,
    output logic              node_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] WPN_A    = ADDR_W'(WORDS_PER_NODE);
    localparam logic [ADDR_W-1:0] WPN_LAST = ADDR_W'(WORDS_PER_NODE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] baddr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_d;
    logic [0:WORD_W-1] a_q;
    logic [0:WORD_W-1] b_q;
    logic [0:BIAS_W-1] bias_q;
    logic              ready_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    // Word presentation request and the source it is taken from
    logic              present_d;
    logic [0:WORD_W-1] src_a_d;
    logic [0:WORD_W-1] src_b_d;
    logic [0:BIAS_W-1] src_bias_d;

`ifdef NODE_FEEDER_PAUSE_EN
    logic              skid_vld_q;
    logic [0:WORD_W-1] skid_a_q;
    logic [0:WORD_W-1] skid_b_q;
    logic [0:BIAS_W-1] skid_bias_q;
    logic              skid_load_d;

    // Present when not paused; a parked word always goes out before fresh memory data
    always_comb begin
        present_d   = (state_q == STREAM) && !pause;
        skid_load_d = (state_q == STREAM) && pause && !skid_vld_q;
        src_a_d     = skid_vld_q ? skid_a_q    : w_data;
        src_b_d     = skid_vld_q ? skid_b_q    : d_data;
        src_bias_d  = skid_vld_q ? skid_bias_q : b_data;
    end

    // Skid register: catches the read that was in flight when pause rose
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_vld_q  <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_bias_q <= '0;
        end else if (skid_load_d) begin
            skid_vld_q  <= 1'b1;
            skid_a_q    <= w_data;
            skid_b_q    <= d_data;
            skid_bias_q <= b_data;
        end else if (present_d) begin
            skid_vld_q  <= 1'b0;
        end
    end
`else
    logic unused_pause;
    assign unused_pause = pause;

    // Strictly back-to-back streaming straight from the memories
    always_comb begin
        present_d  = (state_q == STREAM);
        src_a_d    = w_data;
        src_b_d    = d_data;
        src_bias_d = b_data;
    end
`endif

    // Next word address, saturating on the last word of the run
    always_comb begin
        addr_d = (addr_q == LAST_A) ? addr_q : addr_q + 1'b1;
    end

    // Control FSM with registered outputs; memory data is one cycle behind the address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            baddr_q <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bias_q  <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        baddr_q <= '0;
                        idx_q   <= '0;
                    end
                end
                FETCH: begin
                    addr_q  <= addr_d;
                    baddr_q <= addr_d / WPN_A;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (present_d) begin
                        a_q     <= src_a_d;
                        b_q     <= src_b_d;
                        if (idx_q % WPN_A == '0) begin
                            bias_q <= src_bias_d;
                        end
                        ready_q <= 1'b1;
                        last_q  <= (idx_q % WPN_A == WPN_LAST);
                        idx_q   <= idx_q + 1'b1;
                        addr_q  <= addr_d;
                        baddr_q <= addr_d / WPN_A;
                        if (idx_q == LAST_A) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_addr    = addr_q;
    assign d_addr    = addr_q;
    assign b_addr    = baddr_q;
    assign a         = a_q;
    assign b         = b_q;
    assign bias      = bias_q;
    assign ready     = ready_q;
    assign node_last = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
